// File: rtl/dual_edge_capture_pipe.sv
// dual_edge_capture_pipe: WIDTH-bit capture on rising/falling/both clk edges through per-polarity DEPTH chains.
// Define DUAL_EDGE_CHG_CNT_EN to add chg_cnt, a saturating count of captures whose data changed.
module dual_edge_capture_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             q_valid,
`ifdef DUAL_EDGE_CHG_CNT_EN
  output logic [CNT_W-1:0] chg_cnt,
`endif
  output logic [CNT_W-1:0] sample_cnt
);
  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);
  logic [1:0] mode_r;
  logic [WIDTH-1:0] rise [DEPTH];
  logic [WIDTH-1:0] fall [DEPTH];
  logic [WIDTH-1:0] rise_n [DEPTH];
  logic [WIDTH-1:0] fall_n [DEPTH];
  logic [WIDTH-1:0] r_out, f_out;
  logic [FW-1:0] fill_r, fill_f, fill_f_eff;
  logic gen_r, gen_f;
  logic [CNT_W-1:0] cnt_r, cnt_f;
  logic [CNT_W:0] smp_sum;
  logic mode_chg, cap_r, cap_f;
  assign mode_chg = mode != mode_r;
  assign cap_r = en && !mode_chg && (mode_r == 2'b00 || mode_r == 2'b10);
  assign cap_f = en && (mode_r == 2'b01 || mode_r == 2'b10);
  // The falling domain cannot clear its own fill on a mode change, so a toggled generation bit marks it stale.
  assign fill_f_eff = (gen_f == gen_r) ? fill_f : '0;
  always_comb begin
    rise_n[0] = D;
    fall_n[0] = D;
    for (int i = 1; i < DEPTH; i++) begin
      rise_n[i] = rise[i-1];
      fall_n[i] = fall[i-1];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mode_r <= 2'b00;
      rise   <= '{default: '0};
      r_out  <= '0;
      fill_r <= '0;
      gen_r  <= 1'b0;
      cnt_r  <= '0;
    end else begin
      mode_r <= mode;
      if (mode_chg) begin
        fill_r <= '0;
        gen_r  <= ~gen_r;
      end else if (cap_r) begin
        rise   <= rise_n;
        r_out  <= rise_n[DEPTH-1] ^ f_out;
        fill_r <= fill_r + FW'(fill_r != FULL);
        cnt_r  <= cnt_r + CNT_W'(cnt_r != '1);
      end
    end
  always_ff @(negedge clk or posedge rst)
    if (rst) begin
      fall   <= '{default: '0};
      f_out  <= '0;
      fill_f <= '0;
      gen_f  <= 1'b0;
      cnt_f  <= '0;
    end else begin
      gen_f <= gen_r;
      if (cap_f) begin
        fall   <= fall_n;
        f_out  <= fall_n[DEPTH-1] ^ r_out;
        fill_f <= fill_f_eff + FW'(fill_f_eff != FULL);
        cnt_f  <= cnt_f + CNT_W'(cnt_f != '1);
      end else begin
        fill_f <= fill_f_eff;
      end
    end
  // Each output register folds in the other so Q follows whichever polarity captured last.
  assign Q = r_out ^ f_out;
  assign smp_sum = {1'b0, cnt_r} + {1'b0, cnt_f};
  assign sample_cnt = smp_sum[CNT_W] ? '1 : smp_sum[CNT_W-1:0];
  always_comb
    q_valid = (mode_r == 2'b00) ? fill_r == FULL :
              (mode_r == 2'b01) ? fill_f_eff == FULL :
              (mode_r == 2'b10) ? (fill_r == FULL && fill_f_eff == FULL) : 1'b0;
`ifdef DUAL_EDGE_CHG_CNT_EN
  logic [CNT_W-1:0] chg_r, chg_f;
  logic [CNT_W:0] chg_sum;
  always_ff @(posedge clk or posedge rst)
    if (rst) chg_r <= '0;
    else if (cap_r && D != rise[0]) chg_r <= chg_r + CNT_W'(chg_r != '1);
  always_ff @(negedge clk or posedge rst)
    if (rst) chg_f <= '0;
    else if (cap_f && D != fall[0]) chg_f <= chg_f + CNT_W'(chg_f != '1);
  assign chg_sum = {1'b0, chg_r} + {1'b0, chg_f};
  assign chg_cnt = chg_sum[CNT_W] ? '1 : chg_sum[CNT_W-1:0];
`endif
endmodule
